// File: rtl/shift_engine.sv
// Parallel-load shift engine with LANES-bit serial steps, runtime MSB/LSB-first order,
// a beat counter and busy/done/abort control.
module shift_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1,
  localparam int unsigned BEATS = WIDTH / LANES,
  localparam int unsigned CW    = $clog2(BEATS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lsb_first,
  input  logic             step,
  input  logic             abort,
  input  logic [LANES-1:0] shift_in,
  output logic [LANES-1:0] shift_out,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             order_q, order_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  // Concatenate then slice so LANES == WIDTH needs no special case.
  logic [WIDTH+LANES-1:0] msb_cat, lsb_cat;
  logic [WIDTH-1:0]       msb_next, lsb_next;

  assign msb_cat  = {sreg_q, shift_in};
  assign lsb_cat  = {shift_in, sreg_q};
  assign msb_next = msb_cat[WIDTH-1:0];
  assign lsb_next = lsb_cat[WIDTH+LANES-1:LANES];

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    order_d = order_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          sreg_d  = data_in;
          order_d = lsb_first;
          count_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // abort wins over a simultaneous step and never raises done
        if (abort) begin
          state_d = StIdle;
        end else if (step) begin
          sreg_d  = order_q ? lsb_next : msb_next;
          count_d = count_q + CW'(1);
          if (count_q == LastBeat) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      order_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      order_q <= order_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign shift_out = order_q ? sreg_q[LANES-1:0] : sreg_q[WIDTH-1 -: LANES];
  assign data_out  = sreg_q;
  assign count     = count_q;
  assign busy      = (state_q == StShift);
  assign done      = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Bench for shift_engine: a one-lane and a four-lane instance share control inputs and are
// checked every cycle against an arithmetic word model, plus hand-computed literal checks.
module tb_shift_engine;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] data_in;
  logic       lsb_first;
  logic       step;
  logic       abort;
  logic [3:0] shift_in;

  logic [0:0] so1;
  logic [7:0] do1;
  logic [3:0] cnt1;
  logic       busy1, done1;
  logic [3:0] so4;
  logic [7:0] do4;
  logic [1:0] cnt4;
  logic       busy4, done4;

  int n_vec = 0;
  int n_err = 0;

  shift_engine #(.WIDTH(8), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .lsb_first(lsb_first),
    .step(step), .abort(abort), .shift_in(shift_in[0:0]), .shift_out(so1),
    .data_out(do1), .count(cnt1), .busy(busy1), .done(done1)
  );

  shift_engine #(.WIDTH(8), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .lsb_first(lsb_first),
    .step(step), .abort(abort), .shift_in(shift_in), .shift_out(so4),
    .data_out(do4), .count(cnt4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model, one slot per instance (slot 0: 1 lane, slot 1: 4 lanes).
  logic [7:0] m_reg [2];
  int         m_cnt [2];
  bit         m_busy[2];
  bit         m_done[2];
  bit         m_ord [2];

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] shifted(input logic [7:0] r, input bit lsb, input int l,
                                         input logic [7:0] s);
    logic [7:0] v;
    if (lsb) v = (r >> l) | (s << (8 - l));
    else     v = (r << l) | s;
    return v;
  endfunction

  function automatic int exp_out(input logic [7:0] r, input bit lsb, input int l);
    if (lsb) return int'(r) % (1 << l);
    return int'(r) / (1 << (8 - l));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_reg[i]  <= 8'h00;
        m_cnt[i]  <= 0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_ord[i]  <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (load) begin
            m_reg[i]  <= data_in;
            m_ord[i]  <= lsb_first;
            m_cnt[i]  <= 0;
            m_busy[i] <= 1'b1;
          end
        end else if (abort) begin
          m_busy[i] <= 1'b0;
        end else if (step) begin
          m_reg[i] <= shifted(m_reg[i], m_ord[i], lanes_of(i),
                              (i == 0) ? {7'b0, shift_in[0]} : {4'b0, shift_in});
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == 8 / lanes_of(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("l1 data_out", do1, m_reg[0]);
    chk("l1 count", cnt1, m_cnt[0]);
    chk("l1 busy", busy1, m_busy[0]);
    chk("l1 done", done1, m_done[0]);
    chk("l1 shift_out", so1, exp_out(m_reg[0], m_ord[0], 1));
    chk("l4 data_out", do4, m_reg[1]);
    chk("l4 count", cnt4, m_cnt[1]);
    chk("l4 busy", busy4, m_busy[1]);
    chk("l4 done", done4, m_done[1]);
    chk("l4 shift_out", so4, exp_out(m_reg[1], m_ord[1], 4));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] d, input logic lsb);
    load = 1'b1; data_in = d; lsb_first = lsb;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step(input logic [3:0] sin, input int inst, input int exp_so);
    if (inst == 0) chk("lit l1 shift_out", so1, exp_so);
    else           chk("lit l4 shift_out", so4, exp_so);
    step = 1'b1; shift_in = sin;
    tick();
    step = 1'b0;
  endtask

  task automatic clear;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    rst_n = 1'b0; load = 1'b0; data_in = 8'h00; lsb_first = 1'b0;
    step = 1'b0; abort = 1'b0; shift_in = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset data_out", do1, 0);
    chk("reset count", cnt1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);

    // 0xA5 MSB-first, shifting in ones
    clear();
    do_load(8'hA5, 1'b0);
    chk("busy after load", busy1, 1);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) do_step(4'h1, 0, int'(pat[7-i]));
    chk("a5 data_out", do1, 8'hFF);
    chk("a5 done", done1, 1);
    tick();
    chk("a5 done pulse", done1, 0);

    // 0x96 LSB-first, shifting in zeros
    clear();
    do_load(8'h96, 1'b1);
    pat = 8'h96;
    for (int i = 0; i < 8; i++) do_step(4'h0, 0, int'(pat[i]));
    chk("96 data_out", do1, 8'h00);
    chk("96 count", cnt1, 8);
    chk("96 done", done1, 1);

    // four lanes: 0x3C MSB-first, in 0xA then 0x5
    clear();
    do_load(8'h3C, 1'b0);
    do_step(4'hA, 1, 4'h3);
    do_step(4'h5, 1, 4'hC);
    chk("l4 data_out", do4, 8'hA5);
    chk("l4 done", done4, 1);
    chk("l4 busy", busy4, 0);
    tick();
    chk("l4 done pulse", done4, 0);

    // gapped steps then abort
    clear();
    do_load(8'hF0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_step(4'h0, 0, 1);
      tick(); tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", busy1, 0);
    chk("abort count", cnt1, 3);
    chk("abort done", done1, 0);
    chk("abort data_out", do1, 8'h80);
    tick();
    chk("abort done later", done1, 0);

    // mid-word asynchronous reset
    clear();
    do_load(8'h5A, 1'b0);
    pat = 8'h5A;
    for (int i = 0; i < 4; i++) do_step(4'h0, 0, int'(pat[7-i]));
    step = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async rst data_out", do1, 0);
    chk("async rst count", cnt1, 0);
    chk("async rst busy", busy1, 0);
    chk("async rst shift_out", so1, 0);
    tick();
    step = 1'b0;
    rst_n = 1'b1;
    chk("rst no done", done1, 0);
    do_load(8'h81, 1'b0);
    pat = 8'h81;
    for (int i = 0; i < 8; i++) do_step(4'h0, 0, int'(pat[7-i]));
    chk("81 done", done1, 1);
    chk("81 data_out", do1, 8'h00);

    // load held high through a word, then steps while idle
    tick();
    load = 1'b1; data_in = 8'h0F; lsb_first = 1'b0;
    tick();
    data_in = 8'hFF;
    pat = 8'h0F;
    for (int i = 0; i < 8; i++) do_step(4'h0, 0, int'(pat[7-i]));
    load = 1'b0;
    chk("held load data_out", do1, 8'h00);
    chk("held load done", done1, 1);
    chk("held load count", cnt1, 8);
    step = 1'b1; shift_in = 4'h1;
    tick(); tick(); tick();
    step = 1'b0;
    chk("idle step data_out", do1, 8'h00);
    chk("idle step count", cnt1, 8);
    chk("idle step busy", busy1, 0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
